// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: owns HI/LO, runs multi-cycle mult/div and
// raises a busy-based stall request for the D stage.
module mdu_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  E_md_op,
   input  logic [31:0] E_Fw_Grs,
   input  logic [31:0] E_Fw_Grt,
   input  logic        D_md_use,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] E_md_out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_resHi;
   logic [31:0]       r_resLo;
   logic              r_noCommit;

   logic              w_start;
   logic              w_isMult;
   logic              w_isDiv;
   logic [63:0]       w_prod;
   logic              w_negA;
   logic              w_negB;
   logic [31:0]       w_opA;
   logic [31:0]       w_opB;
   logic [31:0]       w_uq;
   logic [31:0]       w_ur;
   logic [31:0]       w_quot;
   logic [31:0]       w_rem;

   assign w_isMult = (E_md_op == 4'd1) || (E_md_op == 4'd2);
   assign w_isDiv  = (E_md_op == 4'd3) || (E_md_op == 4'd4);
   assign w_start  = w_isMult || w_isDiv;

   // Signed divide is done as unsigned magnitude division with sign fix-up;
   // this also yields the 0x80000000 / -1 overflow result without special casing.
   always_comb begin
      w_prod = '0;
      if (E_md_op == 4'd1)
         w_prod = {{32{E_Fw_Grs[31]}}, E_Fw_Grs} * {{32{E_Fw_Grt[31]}}, E_Fw_Grt};
      else
         w_prod = {32'd0, E_Fw_Grs} * {32'd0, E_Fw_Grt};
      w_negA = (E_md_op == 4'd3) && E_Fw_Grs[31];
      w_negB = (E_md_op == 4'd3) && E_Fw_Grt[31];
      w_opA  = w_negA ? (32'd0 - E_Fw_Grs) : E_Fw_Grs;
      w_opB  = w_negB ? (32'd0 - E_Fw_Grt) : E_Fw_Grt;
      if (w_opB == 32'd0)
         w_opB = 32'd1;
      w_uq   = w_opA / w_opB;
      w_ur   = w_opA % w_opB;
      w_quot = (w_negA ^ w_negB) ? (32'd0 - w_uq) : w_uq;
      w_rem  = w_negA ? (32'd0 - w_ur) : w_ur;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_resHi    <= '0;
         r_resLo    <= '0;
         r_noCommit <= 1'b0;
         HI         <= '0;
         LO         <= '0;
      end else begin
         r_state <= w_nextState;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_noCommit <= w_isDiv && (E_Fw_Grt == 32'd0);
                  if (w_isMult) begin
                     r_resHi <= w_prod[63:32];
                     r_resLo <= w_prod[31:0];
                     r_cnt   <= CNT_W'(MULT_CYCLES);
                  end else begin
                     r_resHi <= w_rem;
                     r_resLo <= w_quot;
                     r_cnt   <= CNT_W'(DIV_CYCLES);
                  end
               end else if (E_md_op == 4'd5) begin
                  HI <= E_Fw_Grs;
               end else if (E_md_op == 4'd6) begin
                  LO <= E_Fw_Grs;
               end
            end
            BUSY: begin
               r_cnt <= r_cnt - 1'b1;
               if ((r_cnt == CNT_W'(1)) && !r_noCommit) begin
                  HI <= r_resHi;
                  LO <= r_resLo;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_start) w_nextState = BUSY;
         BUSY:    if (r_cnt == CNT_W'(1)) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state == BUSY);
      md_stall = D_md_use && ((r_state == BUSY) || w_start);
      E_md_out = 32'd0;
      if (E_md_op == 4'd7)
         E_md_out = HI;
      else if (E_md_op == 4'd8)
         E_md_out = LO;
   end

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed scenarios plus randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_mdu_sched;

   logic        clk;
   logic        reset_n;
   logic [3:0]  E_md_op;
   logic [31:0] E_Fw_Grs;
   logic [31:0] E_Fw_Grt;
   logic        D_md_use;
   logic        busy;
   logic        md_stall;
   logic [31:0] E_md_out;
   logic [31:0] HI;
   logic [31:0] LO;

   int          checks;
   int          errors;
   logic [31:0] hiM;
   logic [31:0] loM;

   mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .E_md_op(E_md_op), .E_Fw_Grs(E_Fw_Grs),
      .E_Fw_Grt(E_Fw_Grt), .D_md_use(D_md_use), .busy(busy), .md_stall(md_stall),
      .E_md_out(E_md_out), .HI(HI), .LO(LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference result {HI,LO} from the architectural arithmetic rules.
   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] oh,
                                         input logic [31:0] ol);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd1: begin p = sa * sb; return p; end
         4'd2: begin p = {32'd0, a} * {32'd0, b}; return p; end
         4'd3: begin
            if (b == 32'd0) return {oh, ol};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 32'd0) return {oh, ol};
            return {a % b, a / b};
         end
         default: return {oh, ol};
      endcase
   endfunction

   // Issue one multi-cycle op and check busy/stall/HI/LO through completion.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dUse, input logic [3:0] injOp, input logic [31:0] injVal);
      logic [63:0] exp;
      int          n;
      n   = (op <= 4'd2) ? 5 : 10;
      exp = model(op, a, b, hiM, loM);
      E_md_op = op; E_Fw_Grs = a; E_Fw_Grt = b; D_md_use = dUse;
      #1;
      checks++;
      if (md_stall !== dUse) begin
         errors++;
         $display("[TB] FAIL start_stall op=%0d got %b want %b", op, md_stall, dUse);
      end
      step();
      E_md_op = 4'd0;
      for (int k = 1; k <= n; k++) begin
         if (k == 2) begin
            E_md_op = injOp;
            E_Fw_Grs = injVal;
            E_Fw_Grt = 32'd0;
         end else begin
            E_md_op = 4'd0;
         end
         #1;
         checks++;
         if (busy !== 1'b1 || md_stall !== dUse) begin
            errors++;
            $display("[TB] FAIL busy_phase op=%0d k=%0d busy=%b stall=%b want busy=1 stall=%b",
                     op, k, busy, md_stall, dUse);
         end
         checks++;
         if (HI !== hiM || LO !== loM) begin
            errors++;
            $display("[TB] FAIL hold_hilo op=%0d k=%0d got %h/%h want %h/%h", op, k, HI, LO, hiM, loM);
         end
         step();
      end
      E_md_op = 4'd0;
      hiM = exp[63:32];
      loM = exp[31:0];
      #1;
      checks++;
      if (busy !== 1'b0 || md_stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_idle op=%0d busy=%b stall=%b want 0/0", op, busy, md_stall);
      end
      checks++;
      if (HI !== hiM || LO !== loM) begin
         errors++;
         $display("[TB] FAIL result op=%0d a=%h b=%h got %h/%h want %h/%h", op, a, b, HI, LO, hiM, loM);
      end
   endtask

   // Single-cycle move-to op in IDLE.
   task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
      E_md_op = op; E_Fw_Grs = v; E_Fw_Grt = $urandom; D_md_use = 1'b0;
      step();
      E_md_op = 4'd0;
      if (op == 4'd5) hiM = v;
      if (op == 4'd6) loM = v;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      E_md_op = 4'($urandom_range(0, 15)); E_Fw_Grs = $urandom; E_Fw_Grt = $urandom;
      D_md_use = 1'b0;
      repeat (3) step();
      checks++;
      if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || md_stall !== 1'b0 || E_md_out !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_state HI=%h LO=%h busy=%b stall=%b out=%h want all 0",
                  HI, LO, busy, md_stall, E_md_out);
      end
      E_md_op = 4'd0;
      reset_n = 1'b1;
      hiM = 32'd0; loM = 32'd0;
      repeat (4) begin
         step();
         checks++;
         if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle busy=%b HI=%h LO=%h want 0", busy, HI, LO);
         end
      end
   endtask

   task automatic test_mult();
      run_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 4'd0, 32'd0);
      run_op(4'd2, 32'hFFFFFFFD, 32'd5, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic test_div();
      run_op(4'd4, 32'd100, 32'd7, 1'b0, 4'd0, 32'd0);
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 4'd0, 32'd0);
   endtask

   task automatic test_overflow_zero();
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 4'd0, 32'd0);
      do_mt(4'd5, 32'h11);
      do_mt(4'd6, 32'h22);
      run_op(4'd4, 32'd1234, 32'd0, 1'b0, 4'd0, 32'd0);
      run_op(4'd3, 32'hCAFEF00D, 32'd0, 1'b1, 4'd0, 32'd0);
   endtask

   task automatic test_stall();
      run_op(4'd1, $urandom, $urandom, 1'b1, 4'd6, 32'h55AA55AA);
      run_op(4'd2, $urandom, $urandom, 1'b0, 4'd5, 32'h12345678);
      run_op(4'd4, $urandom, $urandom_range(1, 50), 1'b1, 4'd1, 32'hFFFFFFFF);
   endtask

   task automatic test_mt_mf();
      do_mt(4'd5, 32'hDEADBEEF);
      E_md_op = 4'd7;
      #1;
      checks++;
      if (E_md_out !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL mfhi_after_mthi got %h want %h", E_md_out, 32'hDEADBEEF);
      end
      do_mt(4'd6, 32'h0BADF00D);
      E_md_op = 4'd8;
      #1;
      checks++;
      if (E_md_out !== 32'h0BADF00D) begin
         errors++;
         $display("[TB] FAIL mflo_after_mtlo got %h want %h", E_md_out, 32'h0BADF00D);
      end
      E_md_op = 4'd11;
      #1;
      checks++;
      if (E_md_out !== 32'd0) begin
         errors++;
         $display("[TB] FAIL md_out_other_op got %h want 0", E_md_out);
      end
      E_md_op = 4'd0;
   endtask

   task automatic test_reset_mid();
      E_md_op = 4'd3; E_Fw_Grs = 32'd1000; E_Fw_Grt = 32'd7; D_md_use = 1'b1;
      step();
      E_md_op = 4'd0;
      step();
      step();
      reset_n = 1'b0;
      #1;
      hiM = 32'd0; loM = 32'd0;
      checks++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_abort busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
      end
      step();
      reset_n = 1'b1;
      D_md_use = 1'b0;
      repeat (12) begin
         step();
         checks++;
         if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("[TB] FAIL no_late_commit busy=%b HI=%h LO=%h want 0", busy, HI, LO);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         op = 4'($urandom_range(1, 8));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20));
         if (op <= 4'd4) begin
            run_op(op, a, b, 1'($urandom_range(0, 1)), 4'd0, 32'd0);
         end else if (op <= 4'd6) begin
            do_mt(op, a);
         end else begin
            E_md_op = op;
            #1;
            checks++;
            if (E_md_out !== ((op == 4'd7) ? hiM : loM)) begin
               errors++;
               $display("[TB] FAIL rand_mf op=%0d got %h want %h", op, E_md_out,
                        (op == 4'd7) ? hiM : loM);
            end
            E_md_op = 4'd0;
            step();
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      hiM = 32'd0;
      loM = 32'd0;
      E_md_op = 4'd0; E_Fw_Grs = 32'd0; E_Fw_Grt = 32'd0; D_md_use = 1'b0;
      reset_n = 1'b0;
      #1;
      test_reset();
      test_mult();
      test_div();
      test_overflow_zero();
      test_stall();
      test_mt_mf();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide unit scheduler for the 5-stage pipeline. Accepts mult/div/move-to/move-from operations from the E stage and runs multi-cycle multiply and divide on the HI/LO pair. It emits a busy-based stall request that is ORed with the register-hazard stall to freeze D and bubble E. It owns HI/LO and supplies the mfhi/mflo read value into the E-stage result path.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- E_md_op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; others = none
- E_Fw_Grs  in  32  forwarded rs operand (dividend / multiplicand / mt source)
- E_Fw_Grt  in  32  forwarded rt operand (divisor / multiplier)
- D_md_use  in  1  D-stage instruction is any of ops 1–8
- busy  out  1  multi-cycle operation in progress
- md_stall  out  1  stall request to the pipeline
- E_md_out  out  32  HI when E_md_op=7, LO when 8, else 0
- HI, LO  out  32 each  architectural registers

## Operation
- States: IDLE, BUSY. Counter cnt (CNT_W bits) and latched result registers res_hi and res_lo.
- Start when E_md_op ∈ {1..4}. Start is accepted only in IDLE. In BUSY, start is ignored; stall guarantees this cannot occur legally.
- On start edge:
  - Compute the result from operands sampled that cycle into res_hi/res_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- In BUSY, cnt decrements each edge. On the edge where cnt==1, write res_hi/res_lo into HI/LO and go to IDLE.
- mult: signed 32x32→64; HI=upper, LO=lower. multu: same, unsigned.
- div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
- 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divisor zero (div/divu): run the full DIV_CYCLES busy; HI/LO are left unchanged at completion.
- mthi/mtlo in IDLE: write HI/LO from E_Fw_Grs at the edge. In BUSY: ignored.
- mfhi/mflo: E_md_out is combinational from the current HI/LO.
- busy = (state==BUSY).
- md_stall = D_md_use && (busy || E_md_op∈{1..4}). The start cycle stalls too, so a dependent op never reaches E while busy.

## Timing
- Reset (async assert, sync release): state=IDLE, cnt=0, HI=LO=0, res_hi=res_lo=0, busy=0, md_stall=0 whenever D_md_use=0, E_md_out=0.
- Op sampled in cycle 0:
  - busy is high in cycles 1..N (N=MULT_CYCLES or DIV_CYCLES).
  - HI/LO hold the new value from cycle N+1, when busy is low.
- md_stall for a D-stage md op present from cycle 0 is high in cycles 0..N. The op enters E in cycle N+1.
- Back-to-back: a new start is legal in cycle N+1. That gives a throughput of one multi-cycle op per N+1 cycles.
- mthi followed by mfhi in the next cycle reads the new value; there is no internal bypass because the write is at the edge.
- Reset asserted mid-operation aborts immediately: busy=0, HI/LO=0, no partial commit.
- HI/LO never change during BUSY except at the completion edge.

## Test plan
- Reset: hold reset_n=0 with arbitrary inputs → HI=LO=0, busy=0, md_stall=0. Deassert → stays idle until an op arrives.
- mult, rs=0xFFFFFFFD (-3), rt=5 → busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. The same operands with multu give HI=0x00000004, LO=0xFFFFFFF1.
- divu, rs=100, rt=7 → busy for 10 cycles; LO=14, HI=2. div, rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Overflow and zero divisor:
  - div 0x80000000 by 0xFFFFFFFF → LO=0x80000000, HI=0.
  - With HI=0x11, LO=0x22, divu by 0 → busy for 10 cycles; HI/LO remain 0x11/0x22.
- Stall: start mult in cycle 0 with D_md_use=1 → md_stall high in cycles 0–5 and low in cycle 6. With D_md_use=0 during busy → md_stall=0. mtlo issued during busy is ignored; LO equals the mult result.
- mthi rs=0xDEADBEEF then mfhi in the next cycle → E_md_out=0xDEADBEEF. Assert reset_n=0 in cycle 3 of a div → busy drops immediately, HI=LO=0, and no commit occurs later.
